// File: rtl/vga_axil_arbiter.sv
// Two-master to one-slave AXI-Lite arbiter for the VGA control plane.
// Read and write directions arbitrate independently with round-robin fairness.
module vga_axil_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                arst_n,

    input  logic [ADDR_W-1:0]   s0_awaddr,
    input  logic                s0_awvalid,
    output logic                s0_awready,
    input  logic [DATA_W-1:0]   s0_wdata,
    input  logic [DATA_W/8-1:0] s0_wstrb,
    input  logic                s0_wvalid,
    output logic                s0_wready,
    output logic [1:0]          s0_bresp,
    output logic                s0_bvalid,
    input  logic                s0_bready,
    input  logic [ADDR_W-1:0]   s0_araddr,
    input  logic                s0_arvalid,
    output logic                s0_arready,
    output logic [DATA_W-1:0]   s0_rdata,
    output logic [1:0]          s0_rresp,
    output logic                s0_rvalid,
    input  logic                s0_rready,

    input  logic [ADDR_W-1:0]   s1_awaddr,
    input  logic                s1_awvalid,
    output logic                s1_awready,
    input  logic [DATA_W-1:0]   s1_wdata,
    input  logic [DATA_W/8-1:0] s1_wstrb,
    input  logic                s1_wvalid,
    output logic                s1_wready,
    output logic [1:0]          s1_bresp,
    output logic                s1_bvalid,
    input  logic                s1_bready,
    input  logic [ADDR_W-1:0]   s1_araddr,
    input  logic                s1_arvalid,
    output logic                s1_arready,
    output logic [DATA_W-1:0]   s1_rdata,
    output logic [1:0]          s1_rresp,
    output logic                s1_rvalid,
    input  logic                s1_rready,

    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready
);

    typedef enum logic [1:0] {WIdle, WAddr, WResp} w_state_e;
    typedef enum logic [1:0] {RIdle, RAddr, RData} r_state_e;

    w_state_e w_state_q;
    logic     w_grant_q;
    logic     w_last_q;
    logic     aw_done_q;
    logic     w_done_q;

    r_state_e r_state_q;
    logic     r_grant_q;
    logic     r_last_q;

    // Tie goes to the master that did not win last; a lone requester always wins.
    function automatic logic pick(input logic req0, input logic req1, input logic last);
        return (req0 & req1) ? ~last : req1;
    endfunction

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid & m_wready;
    assign b_hs  = m_bvalid & m_bready;
    assign ar_hs = m_arvalid & m_arready;
    assign r_hs  = m_rvalid & m_rready;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            w_state_q <= WIdle;
            w_grant_q <= 1'b0;
            w_last_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (w_state_q)
                WIdle: begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    if (s0_awvalid | s1_awvalid) begin
                        w_grant_q <= pick(s0_awvalid, s1_awvalid, w_last_q);
                        w_state_q <= WAddr;
                    end
                end
                WAddr: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                    if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                        w_state_q <= WResp;
                    end
                end
                WResp: begin
                    if (b_hs) begin
                        w_last_q  <= w_grant_q;
                        w_state_q <= WIdle;
                    end
                end
                default: w_state_q <= WIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state_q <= RIdle;
            r_grant_q <= 1'b0;
            r_last_q  <= 1'b1;
        end else begin
            case (r_state_q)
                RIdle: begin
                    if (s0_arvalid | s1_arvalid) begin
                        r_grant_q <= pick(s0_arvalid, s1_arvalid, r_last_q);
                        r_state_q <= RAddr;
                    end
                end
                RAddr: begin
                    if (ar_hs) r_state_q <= RData;
                end
                RData: begin
                    if (r_hs) begin
                        r_last_q  <= r_grant_q;
                        r_state_q <= RIdle;
                    end
                end
                default: r_state_q <= RIdle;
            endcase
        end
    end

    logic w_held, w_addr_ph, w_resp_ph;
    logic r_held, r_addr_ph, r_data_ph;

    assign w_held    = (w_state_q != WIdle);
    assign w_addr_ph = (w_state_q == WAddr);
    assign w_resp_ph = (w_state_q == WResp);
    assign r_held    = (r_state_q != RIdle);
    assign r_addr_ph = (r_state_q == RAddr);
    assign r_data_ph = (r_state_q == RData);

    // Slave-side outputs: payload from the granted master, zero while idle.
    always_comb begin
        m_awaddr  = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        if (w_held) begin
            m_awaddr  = w_grant_q ? s1_awaddr : s0_awaddr;
            m_wdata   = w_grant_q ? s1_wdata  : s0_wdata;
            m_wstrb   = w_grant_q ? s1_wstrb  : s0_wstrb;
            m_awvalid = w_addr_ph & ~aw_done_q & (w_grant_q ? s1_awvalid : s0_awvalid);
            m_wvalid  = w_addr_ph & ~w_done_q  & (w_grant_q ? s1_wvalid  : s0_wvalid);
            m_bready  = w_resp_ph & (w_grant_q ? s1_bready : s0_bready);
        end
    end

    always_comb begin
        m_araddr  = '0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        if (r_held) begin
            m_araddr  = r_grant_q ? s1_araddr : s0_araddr;
            m_arvalid = r_addr_ph & (r_grant_q ? s1_arvalid : s0_arvalid);
            m_rready  = r_data_ph & (r_grant_q ? s1_rready  : s0_rready);
        end
    end

    logic w_addr0, w_addr1, w_resp0, w_resp1;
    logic r_addr0, r_addr1, r_data0, r_data1;

    assign w_addr0 = w_addr_ph & ~w_grant_q;
    assign w_addr1 = w_addr_ph &  w_grant_q;
    assign w_resp0 = w_resp_ph & ~w_grant_q;
    assign w_resp1 = w_resp_ph &  w_grant_q;
    assign r_addr0 = r_addr_ph & ~r_grant_q;
    assign r_addr1 = r_addr_ph &  r_grant_q;
    assign r_data0 = r_data_ph & ~r_grant_q;
    assign r_data1 = r_data_ph &  r_grant_q;

    // Master-side outputs: only the granted master ever sees a handshake or response.
    always_comb begin
        s0_awready = w_addr0 & ~aw_done_q & m_awready;
        s1_awready = w_addr1 & ~aw_done_q & m_awready;
        s0_wready  = w_addr0 & ~w_done_q & m_wready;
        s1_wready  = w_addr1 & ~w_done_q & m_wready;
        s0_bvalid  = w_resp0 & m_bvalid;
        s1_bvalid  = w_resp1 & m_bvalid;
        s0_bresp   = w_resp0 ? m_bresp : 2'b00;
        s1_bresp   = w_resp1 ? m_bresp : 2'b00;
    end

    always_comb begin
        s0_arready = r_addr0 & m_arready;
        s1_arready = r_addr1 & m_arready;
        s0_rvalid  = r_data0 & m_rvalid;
        s1_rvalid  = r_data1 & m_rvalid;
        s0_rdata   = r_data0 ? m_rdata : '0;
        s1_rdata   = r_data1 ? m_rdata : '0;
        s0_rresp   = r_data0 ? m_rresp : 2'b00;
        s1_rresp   = r_data1 ? m_rresp : 2'b00;
    end

endmodule

// File: tb/tb_vga_axil_arbiter.sv
// Self-checking bench for vga_axil_arbiter: vector table plus directed multi-cycle sequences.
module tb_vga_axil_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic arst_n;

    logic [31:0] awaddr [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic        wvalid [2];
    logic        wready [2];
    logic [1:0]  bresp [2];
    logic        bvalid [2];
    logic        bready [2];
    logic [31:0] araddr [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata [2];
    logic [1:0]  rresp [2];
    logic        rvalid [2];
    logic        rready [2];

    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;

    vga_axil_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .arst_n(arst_n),
        .s0_awaddr(awaddr[0]), .s0_awvalid(awvalid[0]), .s0_awready(awready[0]),
        .s0_wdata(wdata[0]), .s0_wstrb(wstrb[0]), .s0_wvalid(wvalid[0]), .s0_wready(wready[0]),
        .s0_bresp(bresp[0]), .s0_bvalid(bvalid[0]), .s0_bready(bready[0]),
        .s0_araddr(araddr[0]), .s0_arvalid(arvalid[0]), .s0_arready(arready[0]),
        .s0_rdata(rdata[0]), .s0_rresp(rresp[0]), .s0_rvalid(rvalid[0]), .s0_rready(rready[0]),
        .s1_awaddr(awaddr[1]), .s1_awvalid(awvalid[1]), .s1_awready(awready[1]),
        .s1_wdata(wdata[1]), .s1_wstrb(wstrb[1]), .s1_wvalid(wvalid[1]), .s1_wready(wready[1]),
        .s1_bresp(bresp[1]), .s1_bvalid(bvalid[1]), .s1_bready(bready[1]),
        .s1_araddr(araddr[1]), .s1_arvalid(arvalid[1]), .s1_arready(arready[1]),
        .s1_rdata(rdata[1]), .s1_rresp(rresp[1]), .s1_rvalid(rvalid[1]), .s1_rready(rready[1]),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave model configuration and observations
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
    logic [31:0] rdata_v = '0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit aw_seen = 0, w_seen = 0, ar_seen = 0;
    int n_aw = 0, n_w = 0, dup_aw = 0, early_b = 0;
    logic [31:0] last_wdata = '0, last_araddr = '0;
    logic [3:0]  last_wstrb = '0;
    logic [31:0] aw_log [$];
    logic [31:0] ar_log [$];

    // Master BFM command/result state
    bit bfm_clr = 1;
    int wgo [2] = '{0, 0};
    int rgo [2] = '{0, 0};
    logic [31:0] wa_c [2], wd_c [2], ra_c [2];
    logic [3:0]  ws_c [2];
    bit wr_busy [2] = '{0, 0};
    bit rd_busy [2] = '{0, 0};
    bit aw_drop [2] = '{0, 0};
    bit w_drop [2] = '{0, 0};
    bit ar_drop [2] = '{0, 0};
    int wcnt [2] = '{0, 0};
    int rcnt [2] = '{0, 0};
    logic [1:0]  wres [2];
    logic [1:0]  rres_resp [2];
    logic [31:0] rres_data [2];
    int stray = 0;
    bit quiet1 = 0;
    int quiet_err = 0;

    // Slave: drive at +2 after the edge, observe handshakes at the falling edge.
    initial begin
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        forever begin
            @(posedge clk);
            #2;
            m_awready = m_awvalid && (aw_cnt >= aw_dly);
            m_wready  = m_wvalid && (w_cnt >= w_dly);
            m_arready = m_arvalid && (ar_cnt >= ar_dly);
            m_bvalid  = aw_seen && w_seen && (b_cnt >= b_dly);
            m_bresp   = m_bvalid ? bresp_v : 2'b00;
            m_rvalid  = ar_seen && (r_cnt >= r_dly);
            m_rdata   = m_rvalid ? rdata_v : 32'h0;
            m_rresp   = m_rvalid ? rresp_v : 2'b00;
            #3;
            if (!arst_n) begin
                aw_seen = 0; w_seen = 0; ar_seen = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            end else begin
                if (m_bready && !(aw_seen && w_seen)) early_b++;
                if (aw_seen && w_seen) begin
                    if (m_bvalid && m_bready) begin
                        aw_seen = 0; w_seen = 0; b_cnt = 0;
                    end else b_cnt++;
                end
                if (m_awvalid) begin
                    if (aw_seen) dup_aw++;
                    if (m_awready) begin
                        n_aw++; aw_log.push_back(m_awaddr); aw_seen = 1; aw_cnt = 0;
                    end else aw_cnt++;
                end
                if (m_wvalid) begin
                    if (m_wready) begin
                        n_w++; last_wdata = m_wdata; last_wstrb = m_wstrb; w_seen = 1; w_cnt = 0;
                    end else w_cnt++;
                end
                if (ar_seen) begin
                    if (m_rvalid && m_rready) begin
                        ar_seen = 0; r_cnt = 0;
                    end else r_cnt++;
                end
                if (m_arvalid) begin
                    if (m_arready) begin
                        last_araddr = m_araddr; ar_log.push_back(m_araddr); ar_seen = 1; ar_cnt = 0;
                    end else ar_cnt++;
                end
            end
        end
    end

    // Master BFMs: drive at +1 after the edge, observe at the falling edge.
    for (genvar g = 0; g < 2; g++) begin : g_mst
        initial begin
            awvalid[g] = 0; awaddr[g] = 0; wvalid[g] = 0; wdata[g] = 0; wstrb[g] = 0;
            arvalid[g] = 0; araddr[g] = 0; bready[g] = 1; rready[g] = 1;
            forever begin
                @(posedge clk);
                #1;
                if (bfm_clr) begin
                    awvalid[g] = 0; awaddr[g] = 0; wvalid[g] = 0; wdata[g] = 0; wstrb[g] = 0;
                    arvalid[g] = 0; araddr[g] = 0;
                    wr_busy[g] = 0; rd_busy[g] = 0; wgo[g] = 0; rgo[g] = 0;
                    aw_drop[g] = 0; w_drop[g] = 0; ar_drop[g] = 0;
                end else begin
                    if (aw_drop[g]) begin awvalid[g] = 0; awaddr[g] = 0; aw_drop[g] = 0; end
                    if (w_drop[g]) begin
                        wvalid[g] = 0; wdata[g] = 0; wstrb[g] = 0; w_drop[g] = 0;
                    end
                    if (ar_drop[g]) begin arvalid[g] = 0; araddr[g] = 0; ar_drop[g] = 0; end
                    if (!wr_busy[g] && wgo[g] > 0) begin
                        wgo[g]--; wr_busy[g] = 1;
                        awvalid[g] = 1; awaddr[g] = wa_c[g];
                        wvalid[g] = 1; wdata[g] = wd_c[g]; wstrb[g] = ws_c[g];
                    end
                    if (!rd_busy[g] && rgo[g] > 0) begin
                        rgo[g]--; rd_busy[g] = 1;
                        arvalid[g] = 1; araddr[g] = ra_c[g];
                    end
                end
                #4;
                if (awvalid[g] && awready[g]) aw_drop[g] = 1;
                if (wvalid[g] && wready[g]) w_drop[g] = 1;
                if (arvalid[g] && arready[g]) ar_drop[g] = 1;
                if (bvalid[g]) begin
                    if (wr_busy[g]) begin wres[g] = bresp[g]; wr_busy[g] = 0; wcnt[g]++; end
                    else stray++;
                end
                if (rvalid[g]) begin
                    if (rd_busy[g]) begin
                        rres_data[g] = rdata[g]; rres_resp[g] = rresp[g];
                        rd_busy[g] = 0; rcnt[g]++;
                    end else stray++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (quiet1 && (awready[1] || wready[1] || bvalid[1] || bresp[1] != 0 ||
                           arready[1] || rvalid[1] || rdata[1] != 0 || rresp[1] != 0))
                quiet_err++;
        end
    end

    function automatic logic any_out();
        logic r = 1'b0;
        for (int i = 0; i < 2; i++)
            r |= awready[i] | wready[i] | bvalid[i] | (|bresp[i]) | arready[i] | rvalid[i] |
                 (|rdata[i]) | (|rresp[i]);
        r |= m_awvalid | (|m_awaddr) | m_wvalid | (|m_wdata) | (|m_wstrb) | m_bready |
             m_arvalid | (|m_araddr) | m_rready;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_wr(input int m, input int target, input string nm);
        int n = 0;
        while (wcnt[m] < target && n < 200) begin tick(); n++; end
        chk(nm, (wcnt[m] >= target), 1);
    endtask

    task automatic wait_rd(input int m, input int target, input string nm);
        int n = 0;
        while (rcnt[m] < target && n < 200) begin tick(); n++; end
        chk(nm, (rcnt[m] >= target), 1);
    endtask

    task automatic set_dly(input int d);
        aw_dly = d; w_dly = d; b_dly = d; ar_dly = d; r_dly = d;
    endtask

    typedef struct {
        bit          wr;
        int          m;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          dly;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic [3:0]  exp_strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt [5];
    int exp_w [2] = '{0, 0};
    int exp_r [2] = '{0, 0};

    initial begin
        vt[0] = '{1, 0, 32'h100, 32'hA5A5A5A5, 4'hF, 2'b00, 32'h0, 0,
                  32'h100, 32'hA5A5A5A5, 4'hF, 2'b00, 32'h0};
        vt[1] = '{1, 1, 32'h204, 32'h0000FFFF, 4'h3, 2'b10, 32'h0, 1,
                  32'h204, 32'h0000FFFF, 4'h3, 2'b10, 32'h0};
        vt[2] = '{0, 1, 32'h30, 32'h0, 4'h0, 2'b00, 32'h12345678, 2,
                  32'h30, 32'h0, 4'h0, 2'b00, 32'h12345678};
        vt[3] = '{0, 0, 32'hFFFFFFFC, 32'h0, 4'h0, 2'b11, 32'h0, 0,
                  32'hFFFFFFFC, 32'h0, 4'h0, 2'b11, 32'h0};
        vt[4] = '{1, 0, 32'h8, 32'hFFFFFFFF, 4'h8, 2'b01, 32'h0, 3,
                  32'h8, 32'hFFFFFFFF, 4'h8, 2'b01, 32'h0};

        arst_n = 0;
        bfm_clr = 1;
        tick();
        tick();
        chk("reset_outputs_zero", any_out(), 0);
        arst_n = 1;
        bfm_clr = 0;
        tick();

        // Tie fairness right after reset: master 0 wins first, then alternation.
        set_dly(0);
        aw_log.delete();
        wa_c[0] = 32'h0; wd_c[0] = 32'h11; ws_c[0] = 4'hF;
        wa_c[1] = 32'h4; wd_c[1] = 32'h22; ws_c[1] = 4'hF;
        wgo[0] = 2; wgo[1] = 2;
        exp_w[0] += 2; exp_w[1] += 2;
        wait_wr(0, exp_w[0], "tie_m0_done");
        wait_wr(1, exp_w[1], "tie_m1_done");
        chk("tie_aw_count", aw_log.size(), 4);
        if (aw_log.size() == 4) begin
            chk("tie_seq0", aw_log[0], 32'h0);
            chk("tie_seq1", aw_log[1], 32'h4);
            chk("tie_seq2", aw_log[2], 32'h0);
            chk("tie_seq3", aw_log[3], 32'h4);
        end
        chk("tie_stray_resp", stray, 0);

        // Single read by master 0 with a 3-cycle slave response.
        ar_dly = 0; r_dly = 2; rdata_v = 32'hDEADBEEF; rresp_v = 2'b00;
        quiet1 = 1; quiet_err = 0;
        ra_c[0] = 32'h10; rgo[0] = 1; exp_r[0]++;
        tick();
        chk("sr_s0_arvalid", arvalid[0], 1);
        chk("sr_m_arvalid_not_yet", m_arvalid, 0);
        tick();
        chk("sr_m_arvalid", m_arvalid, 1);
        chk("sr_m_araddr", m_araddr, 32'h10);
        tick();
        chk("sr_no_early_rvalid", rvalid[0], 0);
        wait_rd(0, exp_r[0], "sr_done");
        chk("sr_rdata", rres_data[0], 32'hDEADBEEF);
        chk("sr_rresp", rres_resp[0], 2'b00);
        chk("sr_s1_quiet", quiet_err, 0);
        quiet1 = 0;

        // Vector table: single transactions with varied slave latency and payload.
        for (int i = 0; i < 5; i++) begin
            vec_t v;
            v = vt[i];
            set_dly(v.dly);
            bresp_v = v.resp; rresp_v = v.resp; rdata_v = v.rdata;
            if (v.wr) begin
                wa_c[v.m] = v.addr; wd_c[v.m] = v.data; ws_c[v.m] = v.strb;
                wgo[v.m] = 1; exp_w[v.m]++;
                wait_wr(v.m, exp_w[v.m], $sformatf("vec%0d_done", i));
                chk($sformatf("vec%0d_awaddr", i), aw_log[aw_log.size()-1], v.exp_addr);
                chk($sformatf("vec%0d_wdata", i), last_wdata, v.exp_data);
                chk($sformatf("vec%0d_wstrb", i), last_wstrb, v.exp_strb);
                chk($sformatf("vec%0d_bresp", i), wres[v.m], v.exp_resp);
            end else begin
                ra_c[v.m] = v.addr;
                rgo[v.m] = 1; exp_r[v.m]++;
                wait_rd(v.m, exp_r[v.m], $sformatf("vec%0d_done", i));
                chk($sformatf("vec%0d_araddr", i), last_araddr, v.exp_addr);
                chk($sformatf("vec%0d_rdata", i), rres_data[v.m], v.exp_rdata);
                chk($sformatf("vec%0d_rresp", i), rres_resp[v.m], v.exp_resp);
            end
        end
        chk("vec_stray_resp", stray, 0);

        // Concurrency: master 0 reads while master 1 writes.
        set_dly(0);
        rdata_v = 32'hCAFEF00D; rresp_v = 2'b00; bresp_v = 2'b10;
        ra_c[0] = 32'h8; rgo[0] = 1; exp_r[0]++;
        wa_c[1] = 32'hC; wd_c[1] = 32'h1234; ws_c[1] = 4'hF; wgo[1] = 1; exp_w[1]++;
        tick();
        tick();
        chk("conc_both_granted", {m_arvalid, m_awvalid}, 2'b11);
        wait_rd(0, exp_r[0], "conc_rd_done");
        wait_wr(1, exp_w[1], "conc_wr_done");
        chk("conc_rdata", rres_data[0], 32'hCAFEF00D);
        chk("conc_bresp", wres[1], 2'b10);
        chk("conc_araddr", last_araddr, 32'h8);
        chk("conc_awaddr", aw_log[aw_log.size()-1], 32'hC);
        chk("conc_wdata", last_wdata, 32'h1234);
        chk("conc_stray_resp", stray, 0);

        // Split AW/W in both orders, master 0 only.
        bresp_v = 2'b00;
        for (int k = 0; k < 2; k++) begin
            int aw0, w0;
            aw_dly = (k == 0) ? 0 : 2;
            w_dly  = (k == 0) ? 2 : 0;
            b_dly = 1;
            aw0 = n_aw; w0 = n_w; dup_aw = 0; early_b = 0;
            wa_c[0] = 32'h40 + k; wd_c[0] = 32'h55; ws_c[0] = 4'hF;
            wgo[0] = 1; exp_w[0]++;
            wait_wr(0, exp_w[0], $sformatf("split%0d_done", k));
            chk($sformatf("split%0d_aw_count", k), n_aw - aw0, 1);
            chk($sformatf("split%0d_w_count", k), n_w - w0, 1);
            chk($sformatf("split%0d_dup_awvalid", k), dup_aw, 0);
            chk($sformatf("split%0d_early_resp", k), early_b, 0);
        end

        // Read stall: grant is held while the slave withholds arready.
        set_dly(0);
        ar_dly = 10; rdata_v = 32'h77;
        ar_log.delete();
        ra_c[1] = 32'h50; rgo[1] = 1; exp_r[1]++;
        tick();
        tick();
        chk("stall_m_arvalid", m_arvalid, 1);
        ra_c[0] = 32'h60; rgo[0] = 1; exp_r[0]++;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("stall%0d_s1_arready", k), arready[1], 0);
            chk($sformatf("stall%0d_s0_arready", k), arready[0], 0);
            chk($sformatf("stall%0d_m_araddr", k), m_araddr, 32'h50);
        end
        wait_rd(1, exp_r[1], "stall_m1_done");
        wait_rd(0, exp_r[0], "stall_m0_done");
        chk("stall_ar_count", ar_log.size(), 2);
        if (ar_log.size() == 2) begin
            chk("stall_order0", ar_log[0], 32'h50);
            chk("stall_order1", ar_log[1], 32'h60);
        end

        // Reset while waiting in the write-response phase.
        set_dly(0);
        b_dly = 1000;
        wa_c[0] = 32'h70; wd_c[0] = 32'h9; ws_c[0] = 4'hF; wgo[0] = 1;
        begin
            int n = 0;
            while (!m_bready && n < 50) begin tick(); n++; end
            chk("rst_reached_wresp", m_bready, 1);
        end
        arst_n = 0;
        bfm_clr = 1;
        tick();
        chk("rst_outputs_zero", any_out(), 0);
        arst_n = 1;
        bfm_clr = 0;
        b_dly = 0;
        aw_log.delete();
        wa_c[0] = 32'h80; wd_c[0] = 32'h1; ws_c[0] = 4'hF;
        wa_c[1] = 32'h84; wd_c[1] = 32'h2; ws_c[1] = 4'hF;
        wgo[0] = 1; wgo[1] = 1;
        exp_w[0]++; exp_w[1]++;
        wait_wr(0, exp_w[0], "rst_m0_done");
        wait_wr(1, exp_w[1], "rst_m1_done");
        chk("rst_aw_count", aw_log.size(), 2);
        if (aw_log.size() == 2) chk("rst_tie_to_m0", aw_log[0], 32'h80);
        chk("final_stray_resp", stray, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
